// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write arbiter and its round-robin picker.
// Holds the FSM encoding and the default NREQ/DW/MAX_BURST constants.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;

    // Beat counter width covers the full 1..15 MAX_BURST range.
    localparam int BEAT_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: lowest requesting index at or above ptr, wrapping at NREQ.
// Purely combinational; no backpressure.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   index,
    output logic            any
);

    int j;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                index     = PW'(j);
            end
        end
    end

endmodule

// File: rtl/my_fifo.sv
// Generic single-clock FIFO; writes while full and reads while empty are dropped.
// Read data is the current head (zero read latency); full/empty come straight from the count.
module my_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          wen,
    input  logic [DW-1:0] in_data,
    output logic          full,
    input  logic          ren,
    output logic [DW-1:0] out_data,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign out_data = mem[rptr];
    assign do_wr    = wen & ~full;
    assign do_rd    = ren & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= in_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + AW'(1);
            if (do_rd) rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester a burst of up to MAX_BURST FIFO writes.
// req-to-gnt latency 1 cycle; fifo_full stalls the burst in place, grant and beat count held.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    input  logic               fifo_full,
    output logic               fifo_wen,
    output logic [DW-1:0]      fifo_wdata,
    output logic               busy
);

    localparam int PW = idx_w(NREQ);

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     ptr_next;
    logic [BEAT_W-1:0] beat;
    logic              last_beat;
    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     pick_index;
    logic              pick_any;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_index),
        .any    (pick_any)
    );

    // gnt is zero outside BURST, so this also keeps the FIFO quiet when idle.
    assign fifo_wen = (|(gnt & req)) & ~fifo_full;

    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) fifo_wdata = fifo_wdata | wdata[i*DW +: DW];
        end
    end

    assign busy      = (state == BURST);
    assign ptr_next  = (winner == PW'(NREQ-1)) ? '0 : winner + PW'(1);
    assign last_beat = (beat == BEAT_W'(MAX_BURST-1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            gnt    <= '0;
            ptr    <= '0;
            winner <= '0;
            beat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt    <= pick_onehot;
                        winner <= pick_index;
                        beat   <= '0;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    // A dropped request ends the burst without a write; a stall keeps everything.
                    if (!req[winner] || (fifo_wen && last_beat)) begin
                        gnt   <= '0;
                        ptr   <= ptr_next;
                        beat  <= '0;
                        state <= IDLE;
                    end else if (fifo_wen) begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed bursts plus random traffic against a queue-based model,
// with a negedge monitor consuming the expected grants and writes.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;

    logic               clk;
    logic               nrst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic               fifo_full;
    logic               fifo_wen;
    logic [DW-1:0]      fifo_wdata;
    logic               busy;

    logic               full_force;
    logic               use_fifo;
    logic               f_full;
    logic               f_empty;
    logic               rd_en;
    logic [DW-1:0]      f_out;

    assign fifo_full = use_fifo ? f_full : full_force;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .wdata      (wdata),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    my_fifo #(.DW(DW), .DEPTH(8)) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .wen      (fifo_wen),
        .in_data  (fifo_wdata),
        .full     (f_full),
        .ren      (rd_en),
        .out_data (f_out),
        .empty    (f_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: who owns the FIFO, how many words it has written, where the next search starts.
    typedef struct { logic [NREQ-1:0] g; logic b; } exp_t;
    typedef struct { int cyc; logic [DW-1:0] d; } wr_t;

    exp_t            gq[$];
    logic [DW-1:0]   wq[$];
    wr_t             wr_log[$];
    logic [NREQ-1:0] grant_log[$];

    int            m_owner;
    int            m_beats;
    int            m_ptr;
    int            seq [NREQ];
    logic [DW-1:0] base [NREQ];
    int            cyc = 0;
    int            full_wr = 0;
    int            gnt_hi = 0;

    function automatic logic [DW-1:0] word_of(input int i);
        return base[i] + DW'(seq[i]);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
    endtask

    task automatic model_eval(input logic [NREQ-1:0] r, input logic f);
        exp_t e;
        e.g = '0;
        if (m_owner >= 0) e.g[m_owner] = 1'b1;
        e.b = (m_owner >= 0);
        gq.push_back(e);
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else if (!f) begin
                wq.push_back(word_of(m_owner));
                seq[m_owner]++;
                m_beats++;
                if (m_beats == MB) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end else if (r != '0) begin
            for (int k = 0; k < NREQ; k++)
                if (m_owner < 0 && r[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
            m_beats = 0;
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = word_of(i);
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic f);
        @(posedge clk);
        #1;
        req        = r;
        full_force = f;
        drive_data();
        model_eval(r, use_fifo ? f_full : f);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        nrst       = 1'b0;
        req        = '0;
        full_force = 1'b0;
        rd_en      = 1'b0;
        use_fifo   = 1'b0;
        model_reset();
        wr_log.delete();
        grant_log.delete();
        full_wr = 0;
        gnt_hi  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    // Monitor: consumes one expected grant per modelled cycle and one expected word per write.
    initial begin
        exp_t            e;
        logic [DW-1:0]   w;
        logic [NREQ-1:0] prev_gnt;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (gq.size() > 0) begin
                    e = gq.pop_front();
                    chk("gnt", 32'(gnt), 32'(e.g));
                    chk("busy", 32'(busy), 32'(e.b));
                end
                if (fifo_wen) begin
                    if (wq.size() == 0) chk("unexpected_write", 32'(fifo_wen), 32'(0));
                    else begin
                        w = wq.pop_front();
                        chk("wdata", 32'(fifo_wdata), 32'(w));
                    end
                end else if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("missing_write", 32'(fifo_wen), 32'(1));
                end
                if (gnt == '0) chk("wdata_idle", 32'(fifo_wdata), 32'(0));
                if (fifo_wen && fifo_full) full_wr++;
                if (gnt != '0) gnt_hi++;
                if (gnt != '0 && prev_gnt == '0) grant_log.push_back(gnt);
                if (fifo_wen) wr_log.push_back('{cyc, fifo_wdata});
                prev_gnt = gnt;
            end else begin
                prev_gnt = '0;
            end
            cyc++;
        end
    end

    initial begin
        int            c0;
        int            n;
        int            stall;
        int            nread;
        int            wait_cnt;
        logic          saw_full;
        logic [NREQ-1:0] r;
        logic [DW-1:0] d;
        int            nxt [NREQ];
        int            ord_id [5];

        nrst       = 1'b0;
        req        = '0;
        wdata      = '0;
        full_force = 1'b0;
        use_fifo   = 1'b0;
        rd_en      = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) base[i] = '0;
        #2;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_wen", 32'(fifo_wen), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_wdata", 32'(fifo_wdata), 32'(0));

        // Single requester: two bursts 0x11-0x14 and 0x15-0x16 separated by one idle cycle.
        do_reset();
        base[0] = 8'h00; base[1] = 8'h11; base[2] = 8'h40; base[3] = 8'h60;
        c0 = 0;
        for (int k = 0; k < 12; k++) begin
            step((seq[1] < 6) ? 4'b0010 : 4'b0000, 1'b0);
            if (k == 0) c0 = cyc;
        end
        chk("p1_nwrites", 32'(wr_log.size()), 32'(6));
        for (int k = 0; k < 6 && k < wr_log.size(); k++)
            chk("p1_data", 32'(wr_log[k].d), 32'(8'h11 + k));
        if (wr_log.size() >= 6) begin
            chk("p1_latency", 32'(wr_log[0].cyc - c0), 32'(1));
            chk("p1_back2back", 32'(wr_log[3].cyc - wr_log[0].cyc), 32'(3));
            chk("p1_gap", 32'(wr_log[4].cyc - wr_log[3].cyc), 32'(2));
        end
        chk("p1_ngrants", 32'(grant_log.size()), 32'(2));

        // All requesting: grant order 0,1,2,3,0, four writes each.
        do_reset();
        for (int i = 0; i < NREQ; i++) base[i] = DW'(i << 4);
        for (int k = 0; k < 25; k++) step(4'b1111, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        ord_id = '{0, 1, 2, 3, 0};
        chk("p2_ngrants", 32'(grant_log.size()), 32'(5));
        chk("p2_nwrites", 32'(wr_log.size()), 32'(20));
        for (int b = 0; b < 5; b++) begin
            if (b < grant_log.size()) chk("p2_order", 32'(grant_log[b]), 32'(1 << ord_id[b]));
            n = 0;
            for (int j = 4*b; j < 4*b + 4; j++)
                if (j < wr_log.size() && wr_log[j].d[7:4] == 4'(ord_id[b])) n++;
            chk("p2_burst_len", 32'(n), 32'(4));
        end

        // Full for three cycles after the second write of a burst.
        do_reset();
        base[0] = 8'h30;
        stall = 0;
        for (int k = 0; k < 12; k++) begin
            logic f;
            f = (seq[0] == 2 && stall < 3);
            if (f) stall++;
            step((seq[0] < 4) ? 4'b0001 : 4'b0000, f);
        end
        chk("p3_nwrites", 32'(wr_log.size()), 32'(4));
        chk("p3_write_while_full", 32'(full_wr), 32'(0));
        chk("p3_ngrants", 32'(grant_log.size()), 32'(1));
        chk("p3_gnt_cycles", 32'(gnt_hi), 32'(7));

        // Requester 2 drops after two writes; the search must then start at 3, not 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) base[i] = DW'(i << 4);
        for (int k = 0; k < 12; k++) begin
            r    = '0;
            r[3] = (seq[3] < 2);
            r[2] = (seq[2] < 2);
            r[0] = (k >= 3) && (seq[0] < 1);
            step(r, 1'b0);
        end
        chk("p4_ngrants", 32'(grant_log.size()), 32'(3));
        if (grant_log.size() >= 3) begin
            chk("p4_first", 32'(grant_log[0]), 32'(4'b0100));
            chk("p4_after_release", 32'(grant_log[1]), 32'(4'b1000));
            chk("p4_third", 32'(grant_log[2]), 32'(4'b0001));
        end
        chk("p4_nwrites", 32'(wr_log.size()), 32'(5));

        // Reset during beat 2, then re-arbitrate from pointer 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) base[i] = DW'(i << 4);
        for (int k = 0; k < 3; k++) step(4'b0100, 1'b0);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("p5_wr_before_rst", 32'(wr_log.size()), 32'(2));
        chk("p5_gnt", 32'(gnt), 32'(0));
        chk("p5_wen", 32'(fifo_wen), 32'(0));
        chk("p5_busy", 32'(busy), 32'(0));
        chk("p5_wdata", 32'(fifo_wdata), 32'(0));
        model_reset();
        grant_log.delete();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        req  = 4'b1010;
        drive_data();
        model_eval(4'b1010, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b1010, 1'b0);
        chk("p5_regrant_cnt", 32'(grant_log.size()), 32'(1));
        if (grant_log.size() > 0) chk("p5_first_grant", 32'(grant_log[0]), 32'(4'b0010));

        // End to end through the FIFO: fill it, stall, then drain and check per-requester order.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            base[i] = DW'(i << 4);
            nxt[i]  = 0;
        end
        use_fifo = 1'b1;
        saw_full = 1'b0;
        wait_cnt = 0;
        nread    = 0;
        for (int k = 0; k < 400 && nread < 16; k++) begin
            r = '0;
            for (int i = 0; i < NREQ; i++) r[i] = (seq[i] < 4) && ($urandom_range(0, 3) != 0);
            step(r, 1'b0);
            if (f_full) saw_full = 1'b1;
            if (saw_full) wait_cnt++;
            rd_en = (wait_cnt > 4) && !f_empty && ($urandom_range(0, 1) == 1);
            if (rd_en) begin
                d = f_out;
                if (d[7:4] < 4'(NREQ)) begin
                    chk("p6_order", 32'(d[3:0]), 32'(nxt[d[7:4]]));
                    nxt[d[7:4]]++;
                end else begin
                    chk("p6_source", 32'(d[7:4]), 32'(NREQ - 1));
                end
                nread++;
            end
        end
        @(negedge clk);
        #1;
        chk("p6_saw_full", 32'(saw_full), 32'(1));
        chk("p6_nread", 32'(nread), 32'(16));
        chk("p6_write_while_full", 32'(full_wr), 32'(0));

        // Random requests and random full against the model.
        do_reset();
        for (int i = 0; i < NREQ; i++) base[i] = DW'($urandom_range(0, 255));
        for (int k = 0; k < 300; k++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        step(4'b0000, 1'b0);
        @(negedge clk);
        #1;
        chk("end_pending_writes", 32'(wq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
